// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch front end: default widths,
// the JAL opcode, the fetch FSM state encodings and the J-type offset helper.
package inst_fetcher_pkg;

  localparam int InstWidth = 32;
  localparam int AddrWidth = 32;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  // J-type immediate, byte offset (bit 0 always zero), 21 bits signed.
  function automatic logic [20:0] jal_offset(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// First-word-fall-through queue of fetched {pc, inst, pred} entries.
// Head entry is visible combinationally; output reads zero while empty.
// Push when full and pop when empty are ignored. Flush empties the queue.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[head];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed through the valid-masked head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail] <= din;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: issues one sequential fetch at a time to the
// memory controller, queues responses with their PC for the decoder, and
// restarts from clr_pc on a flush.
// Optional macro IF_PREDECODE_JAL_EN: predecode JAL responses so the next
// fetch goes to the jump target and the entry is marked predicted-taken.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int ADDR_WIDTH  = AddrWidth,
  parameter int INST_WIDTH  = InstWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] clr_pc,
  output logic                  MC_req,
  output logic [ADDR_WIDTH-1:0] MC_addr,
  input  logic                  MC_enable,
  input  logic [INST_WIDTH-1:0] MC_inst,
  output logic                  DC_valid,
  output logic [INST_WIDTH-1:0] DC_inst,
  output logic [ADDR_WIDTH-1:0] DC_pc,
  output logic                  DC_pred_taken,
  input  logic                  DC_ready
);

  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  fetch_state_e          state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  req_n;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  pred;

  logic                  q_push, q_pop, q_flush;
  logic                  q_empty, q_full;
  logic [CNT_W-1:0]      q_count;
  logic [ENTRY_W-1:0]    q_dout;

`ifdef IF_PREDECODE_JAL_EN
  logic        is_jal;
  logic [20:0] jal_off;

  assign is_jal  = (MC_inst[6:0] == OPCODE_JAL);
  assign jal_off = jal_offset(MC_inst);
  assign next_pc = is_jal ? pc + {{(ADDR_WIDTH-21){jal_off[20]}}, jal_off}
                          : pc + ADDR_WIDTH'(4);
  assign pred    = is_jal;
`else
  assign next_pc = pc + ADDR_WIDTH'(4);
  assign pred    = 1'b0;
`endif

  // Next-state, request and queue control; flush overrides everything, rdy=0 holds.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = MC_req;
    addr_n  = MC_addr;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
    if (rdy) begin
      if (clr) begin
        q_flush = 1'b1;
        pc_n    = clr_pc;
        req_n   = 1'b0;
        state_n = IDLE;
      end else begin
        q_pop = DC_valid & DC_ready;
        case (state)
          IDLE: begin
            if (q_count < DEPTH_C) begin
              req_n   = 1'b1;
              addr_n  = pc;
              state_n = WAIT;
            end
          end
          WAIT: begin
            if (MC_enable && !q_full) begin
              q_push  = 1'b1;
              pc_n    = next_pc;
              req_n   = 1'b0;
              state_n = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // FSM state, fetch PC and the registered memory-controller request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pc      <= '0;
      MC_req  <= 1'b0;
      MC_addr <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      MC_req  <= req_n;
      MC_addr <= addr_n;
    end
  end

  inst_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .din   ({pc, MC_inst, pred}),
    .dout  (q_dout),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  assign DC_valid = ~q_empty;
  assign {DC_pc, DC_inst, DC_pred_taken} = q_dout;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: the memory-controller model pushes the
// expected {pc, inst, pred} per accepted response; a decoder-side monitor
// pops and compares on every handshake.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic [31:0] clr_pc;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_enable;
  logic [31:0] MC_inst;
  logic        DC_valid;
  logic [31:0] DC_inst;
  logic [31:0] DC_pc;
  logic        DC_pred_taken;
  logic        DC_ready;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } item_t;

  item_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  inst_fetcher #(
    .QUEUE_DEPTH (16),
    .ADDR_WIDTH  (32),
    .INST_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .clr           (clr),
    .clr_pc        (clr_pc),
    .MC_req        (MC_req),
    .MC_addr       (MC_addr),
    .MC_enable     (MC_enable),
    .MC_inst       (MC_inst),
    .DC_valid      (DC_valid),
    .DC_inst       (DC_inst),
    .DC_pc         (DC_pc),
    .DC_pred_taken (DC_pred_taken),
    .DC_ready      (DC_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  // Expected entry for a response accepted at exp_pc, then advance exp_pc.
  task automatic model_step(input logic [31:0] inst);
    item_t it;
    logic  jal;
`ifdef IF_PREDECODE_JAL_EN
    jal = (inst[6:0] == 7'h6F);
`else
    jal = 1'b0;
`endif
    it.pc   = exp_pc;
    it.inst = inst;
    it.pred = jal;
    sb.push_back(it);
    if (jal)
      exp_pc = exp_pc + {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    else
      exp_pc = exp_pc + 32'd4;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    @(negedge clk);
    while (!MC_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!MC_req) check("req_timeout", {63'd0, MC_req}, 64'd1);
  endtask

  // Wait for a request, check its address, answer after lat cycles.
  task automatic serve(input logic [31:0] inst, input int lat, input bit pop_too, output int gap);
    wait_req(gap);
    check("mc_addr", {32'd0, MC_addr}, {32'd0, exp_pc});
    repeat (lat) @(posedge clk);
    #1;
    MC_enable = 1'b1;
    MC_inst   = inst;
    if (pop_too) DC_ready = 1'b1;
    @(posedge clk);
    #1;
    MC_enable = 1'b0;
    if (pop_too) DC_ready = 1'b0;
    model_step(inst);
  endtask

  task automatic flush_to(input logic [31:0] target);
    @(posedge clk);
    #1;
    clr    = 1'b1;
    clr_pc = target;
    @(posedge clk);
    #1;
    clr = 1'b0;
    sb.delete();
    exp_pc = target;
  endtask

  // Decoder-side monitor: compare the head against the scoreboard on each pop.
  always @(negedge clk) begin
    item_t e;
    if (rst && rdy && !clr && DC_valid && DC_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", {63'd0, DC_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("dc_pc",   {32'd0, DC_pc},   {32'd0, e.pc});
        check("dc_inst", {32'd0, DC_inst}, {32'd0, e.inst});
        check("dc_pred", {63'd0, DC_pred_taken}, {63'd0, e.pred});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g;
    int          reqs;
    logic [31:0] last_pc;
    logic [31:0] jal_next;
    logic        jal_pred;

    rst       = 1'b0;
    rdy       = 1'b1;
    clr       = 1'b0;
    clr_pc    = '0;
    MC_enable = 1'b0;
    MC_inst   = '0;
    DC_ready  = 1'b0;
    exp_pc    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   {63'd0, MC_req}, 64'd0);
    check("rst_addr",  {32'd0, MC_addr}, 64'd0);
    check("rst_valid", {63'd0, DC_valid}, 64'd0);
    check("rst_inst",  {32'd0, DC_inst}, 64'd0);
    check("rst_pc",    {32'd0, DC_pc}, 64'd0);
    check("rst_pred",  {63'd0, DC_pred_taken}, 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    DC_ready = 1'b1;

    // Sequential fetch with 3-cycle memory latency and one idle cycle between requests
    for (int i = 0; i < 3; i++) begin
      serve(mk_inst(exp_pc), 3, 1'b0, g);
      check("req_gap", 64'(g), 64'd1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("seq_drained", {63'd0, DC_valid}, 64'd0);

    // Fill to full from pc 0 with the decoder stalled
    DC_ready = 1'b0;
    flush_to(32'h0);
    for (int i = 0; i < 16; i++) serve(mk_inst(exp_pc), 1, 1'b0, g);
    reqs = 0;
    repeat (8) begin
      @(negedge clk);
      if (MC_req) reqs++;
    end
    check("full_no_req", 64'(reqs), 64'd0);
    check("full_valid",  {63'd0, DC_valid}, 64'd1);
    check("full_head",   {32'd0, DC_pc}, 64'd0);
    @(posedge clk);
    #1 DC_ready = 1'b1;
    @(posedge clk);
    #1 DC_ready = 1'b0;
    check("refill_exp", {32'd0, exp_pc}, 64'h40);
    serve(mk_inst(exp_pc), 1, 1'b0, g);
    reqs = 0;
    repeat (6) begin
      @(negedge clk);
      if (MC_req) reqs++;
    end
    check("one_req_only", 64'(reqs), 64'd0);

    // Drain, then simultaneous push and pop at count=1 across the pointer wrap
    @(posedge clk);
    #1 DC_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 DC_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", {63'd0, DC_valid}, 64'd0);
    serve(mk_inst(exp_pc), 1, 1'b0, g);
    for (int i = 0; i < 18; i++) begin
      last_pc = exp_pc;
      serve(mk_inst(exp_pc), 1, 1'b1, g);
      @(negedge clk);
      check("pp_valid", {63'd0, DC_valid}, 64'd1);
      check("pp_pc",    {32'd0, DC_pc}, {32'd0, last_pc});
    end
    @(posedge clk);
    #1 DC_ready = 1'b1;
    @(posedge clk);
    #1 DC_ready = 1'b0;
    @(negedge clk);
    check("pp_count1", {63'd0, DC_valid}, 64'd0);

    // Flush while waiting, with a response in the same cycle
    serve(mk_inst(exp_pc), 1, 1'b0, g);
    wait_req(g);
    @(posedge clk);
    #1;
    clr       = 1'b1;
    clr_pc    = 32'h1000;
    MC_enable = 1'b1;
    MC_inst   = mk_inst(exp_pc);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    MC_enable = 1'b0;
    sb.delete();
    exp_pc = 32'h1000;
    @(negedge clk);
    check("flush_valid", {63'd0, DC_valid}, 64'd0);
    check("flush_req",   {63'd0, MC_req}, 64'd0);
    DC_ready = 1'b1;
    serve(mk_inst(exp_pc), 2, 1'b0, g);
    check("flush_next", {32'd0, exp_pc}, 64'h1004);

    // rdy stall during WAIT with a response strobe that must be ignored
    wait_req(g);
    @(posedge clk);
    #1 rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      MC_enable = (k == 2);
      MC_inst   = 32'hDEAD0013;
      @(negedge clk);
      check("stall_req",   {63'd0, MC_req}, 64'd1);
      check("stall_addr",  {32'd0, MC_addr}, {32'd0, exp_pc});
      check("stall_valid", {63'd0, DC_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    MC_enable = 1'b0;
    rdy       = 1'b1;
    @(negedge clk);
    check("stall_nopush", {63'd0, DC_valid}, 64'd0);
    serve(mk_inst(exp_pc), 1, 1'b0, g);
    repeat (3) @(posedge clk);

    // JAL response at pc 0x8
`ifdef IF_PREDECODE_JAL_EN
    jal_next = 32'h18;
    jal_pred = 1'b1;
`else
    jal_next = 32'hC;
    jal_pred = 1'b0;
`endif
    DC_ready = 1'b0;
    flush_to(32'h8);
    serve(32'h0100006F, 1, 1'b0, g);
    @(negedge clk);
    check("jal_head_pc", {32'd0, DC_pc}, 64'h8);
    check("jal_pred",    {63'd0, DC_pred_taken}, {63'd0, jal_pred});
    wait_req(g);
    check("jal_next", {32'd0, MC_addr}, {32'd0, jal_next});
    serve(mk_inst(exp_pc), 1, 1'b0, g);
    @(posedge clk);
    #1 DC_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_left", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end fetch stage directly downstream of the memory controller's instruction-fetch port.
- Generates sequential fetch requests and holds the PC of the request in flight.
- Buffers each returned 32-bit instruction with its PC in a FWFT queue that the decoder drains.
- On `clr` (misprediction or exception flush) it discards all buffered and in-flight instructions and restarts at a supplied PC.

Parameters:
- QUEUE_DEPTH, 16, queue entries; power of two, >=2.
- ADDR_WIDTH, 32, PC width.
- INST_WIDTH, 32, instruction width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; 0 freezes all state
- clr  in  1  flush request, sampled on clk
- clr_pc  in  ADDR_WIDTH  restart PC, valid with clr
- MC_req  out  1  fetch request to memory controller (level)
- MC_addr  out  ADDR_WIDTH  fetch address, stable while MC_req=1
- MC_enable  in  1  one-cycle response strobe from memory controller
- MC_inst  in  INST_WIDTH  fetched instruction, valid with MC_enable
- DC_valid  out  1  queue head valid
- DC_inst  out  INST_WIDTH  head instruction
- DC_pc  out  ADDR_WIDTH  head PC
- DC_pred_taken  out  1  head predicted-taken flag (see Optional Feature)
- DC_ready  in  1  decoder pops head when DC_valid&DC_ready

Behaviour:
- **Reset:** `rst`=0, asynchronous.
  - pc=0, state=IDLE.
  - MC_req=0, MC_addr=0.
  - Queue empty (head=tail=count=0), so DC_valid=0.
  - DC_inst, DC_pc and DC_pred_taken read 0.
- **Freeze:** all updates happen only when `rdy`=1. With `rdy`=0, registers and outputs hold, and MC_enable/DC_ready are ignored.
- **FSM, two states (IDLE, WAIT):**
  - IDLE: if count < QUEUE_DEPTH and clr=0, register MC_req<=1 and MC_addr<=pc, then go to WAIT.
  - WAIT: MC_req and MC_addr are held until MC_enable=1. At that edge:
    - push {pc, MC_inst, pred} into the queue;
    - pc <= next_pc (pc+4, wrapping mod 2^ADDR_WIDTH);
    - MC_req <= 0, go to IDLE.
  - Back-to-back throughput: one request per 2 cycles plus memory latency. IDLE always spends exactly one cycle with MC_req=0.
- **Full check:** only one request is ever outstanding. The request is issued only when count <= QUEUE_DEPTH-1, so a push never overflows. A simultaneous pop in the push cycle leaves count unchanged.
- **Queue:**
  - First-word-fall-through: DC_* are driven combinationally from the head entry.
  - Pop when DC_valid=0 is ignored.
  - Pointers wrap mod QUEUE_DEPTH.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
- **Flush (`clr`=1 with `rdy`=1)** has priority over every other event in that cycle:
  - queue cleared (head=tail=count=0);
  - pc <= clr_pc, MC_req <= 0, state <= IDLE;
  - any MC_enable in the same cycle is discarded;
  - a DC_ready pop in the same cycle has no effect beyond the clear.
- **Flush contract:** the memory controller aborts its in-flight fetch on the same clr, so no stale MC_enable arrives after a flush. The first post-flush request (MC_addr=clr_pc) is issued the cycle after clr drops.
- **Spurious response:** MC_enable while in IDLE is ignored.
- **Asynchronous reset mid-WAIT** behaves as a full reset; no response is retained.

Optional Feature:
- **Macro: IF_PREDECODE_JAL_EN**
- **Defined:**
  - On MC_enable, if MC_inst[6:0]==7'b1101111 (JAL), next_pc = pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - The pushed pred flag is 1, so the decoder sees DC_pred_taken=1 for that entry.
  - The next MC_addr is the jump target.
- **Undefined:** next_pc is always pc+4 and DC_pred_taken is constant 0. The predecode logic is absent.

Decomposition:
- **Shared defines file** (the existing global one) holds:
  - `InstWidth`, `AddrWidth`;
  - OPCODE_JAL;
  - the IDLE/WAIT state encodings.
- **Sub-module inst_queue:**
  - a parameterised FWFT FIFO of {pc, inst, pred};
  - ports: push/pop/flush, full/empty/count.
- inst_fetcher owns the FSM, the pc register and the predecode logic.

Test Plan:
- **Reset then sequential fetch:**
  - Stimulus: rst=0 for 2 cycles, release; memory responds with MC_enable 3 cycles after each MC_req rise; DC_ready=1.
  - Response: MC_addr sequence 0x0, 0x4, 0x8. DC_pc/DC_inst pairs match in order. MC_req=0 for exactly 1 cycle between requests.
- **Fill to full:**
  - Stimulus: DC_ready=0 with a QUEUE_DEPTH=16 build.
  - Response: 16 responses accepted, then MC_req stays 0 and count=16. One pop gives exactly one new request, at MC_addr=0x40.
- **Flush while WAIT:**
  - Stimulus: clr=1, clr_pc=0x1000 while MC_req=1; MC_enable is asserted in the same cycle.
  - Response: DC_valid=0 next cycle, that response is dropped, and the next MC_addr is 0x1000.
- **Simultaneous push and pop at count=1:**
  - Response: count stays 1, DC_pc advances to the newly pushed PC, and the pointers wrap correctly across entry 15->0.
- **rdy stall:**
  - Stimulus: rdy=0 for 5 cycles while WAIT, with MC_enable pulsed during the stall.
  - Response: no push, MC_req and MC_addr unchanged; normal operation resumes after rdy=1.
- **IF_PREDECODE_JAL_EN:**
  - Stimulus: response 0x0100006F at pc 0x8.
  - Response: DC_pred_taken=1 for that entry and the next MC_addr is 0x18. Without the macro, the next MC_addr is 0xC and DC_pred_taken=0.
